// File: rtl/vc_pkg.sv
// Shared types and defaults for the victim buffer: entry record, default sizes, occupancy width helper.
package vc_pkg;

  localparam int VC_ENTRIES = 4;
  localparam int VC_TAG_W   = 26;
  localparam int VC_DATA_W  = 32;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [VC_TAG_W-1:0]  tag;
    logic [VC_DATA_W-1:0] data;
  } vc_entry_t;

  // Width able to hold 0..entries inclusive, i.e. $clog2(entries)+1.
  function automatic int vc_occ_w(input int entries);
    int w;
    w = 0;
    while ((1 << w) < entries) w = w + 1;
    return w + 1;
  endfunction

endpackage

// File: rtl/vc_first_free.sv
// Priority encoder: index of the lowest clear bit in a valid vector; combinational, no flow control.
module vc_first_free #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  output logic          found,
  output logic [IW-1:0] index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        found = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/victim_buffer.sv
// Fully-associative victim cache behind a direct-mapped L1; probe response one cycle later,
// dirty displaced lines pulse out on the write-back port; no backpressure on either side.
module victim_buffer
  import vc_pkg::*;
#(
  parameter int ENTRIES = VC_ENTRIES,
  parameter int TAG_W   = VC_TAG_W,
  parameter int DATA_W  = VC_DATA_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           lookup_valid,
  input  logic [TAG_W-1:0]               lookup_tag,
  input  logic                           insert_valid,
  input  logic [TAG_W-1:0]               insert_tag,
  input  logic [DATA_W-1:0]              insert_data,
  input  logic                           insert_dirty,
  output logic                           resp_valid,
  output logic                           resp_hit,
  output logic [DATA_W-1:0]              resp_data,
  output logic                           resp_dirty,
  output logic                           wb_valid,
  output logic [TAG_W-1:0]               wb_tag,
  output logic [DATA_W-1:0]              wb_data,
  output logic [vc_occ_w(ENTRIES)-1:0]   occupancy
);

  localparam int IW = $clog2(ENTRIES);
  localparam int OW = vc_occ_w(ENTRIES);

  vc_entry_t          ent_q [ENTRIES];
  vc_entry_t          ent_d [ENTRIES];
  logic [IW-1:0]      repl_ptr;
  logic [ENTRIES-1:0] valid_vec, probe_miss_vec, ins_miss_vec;
  logic               probe_hit, ins_match, free_found, replace, same_slot;
  logic [IW-1:0]      probe_idx, ins_match_idx, free_idx, ins_idx;
  logic [OW-1:0]      occ_d;

  always_comb begin
    valid_vec      = '0;
    probe_miss_vec = '1;
    ins_miss_vec   = '1;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_vec[i]      = ent_q[i].valid;
      probe_miss_vec[i] = !(lookup_valid && ent_q[i].valid && ent_q[i].tag == VC_TAG_W'(lookup_tag));
      ins_miss_vec[i]   = !(insert_valid && ent_q[i].valid && ent_q[i].tag == VC_TAG_W'(insert_tag));
    end
  end

  // The encoder finds the lowest clear bit, so inverted match vectors yield the matching slot.
  vc_first_free #(.N(ENTRIES), .IW(IW)) u_free  (.valid(valid_vec),      .found(free_found), .index(free_idx));
  vc_first_free #(.N(ENTRIES), .IW(IW)) u_probe (.valid(probe_miss_vec), .found(probe_hit),  .index(probe_idx));
  vc_first_free #(.N(ENTRIES), .IW(IW)) u_imatch(.valid(ins_miss_vec),   .found(ins_match),  .index(ins_match_idx));

  always_comb begin
    ins_idx   = repl_ptr;
    same_slot = probe_hit && ins_match && (probe_idx == ins_match_idx);
    if (ins_match)       ins_idx = ins_match_idx;
    else if (probe_hit)  ins_idx = probe_idx;
    else if (free_found) ins_idx = free_idx;
    replace = insert_valid && !ins_match && !probe_hit && !free_found;
  end

  always_comb begin
    ent_d = ent_q;
    if (probe_hit) ent_d[probe_idx].valid = 1'b0;
    if (insert_valid) begin
      ent_d[ins_idx].valid = 1'b1;
      ent_d[ins_idx].tag   = VC_TAG_W'(insert_tag);
      ent_d[ins_idx].data  = VC_DATA_W'(insert_data);
      // A line probed out in the same cycle comes back fresh, so its old dirty bit is not merged.
      ent_d[ins_idx].dirty = (ins_match && !same_slot) ? (ent_q[ins_idx].dirty | insert_dirty)
                                                        : insert_dirty;
    end
    occ_d = '0;
    for (int i = 0; i < ENTRIES; i++) occ_d = occ_d + OW'(ent_d[i].valid);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
      repl_ptr   <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_data  <= '0;
      resp_dirty <= 1'b0;
      wb_valid   <= 1'b0;
      wb_tag     <= '0;
      wb_data    <= '0;
      occupancy  <= '0;
    end else begin
      ent_q      <= ent_d;
      occupancy  <= occ_d;
      if (replace) repl_ptr <= repl_ptr + 1'b1;
      resp_valid <= lookup_valid;
      resp_hit   <= probe_hit;
      resp_data  <= probe_hit ? DATA_W'(ent_q[probe_idx].data) : '0;
      resp_dirty <= probe_hit && ent_q[probe_idx].dirty;
      wb_valid   <= replace && ent_q[repl_ptr].dirty;
      wb_tag     <= (replace && ent_q[repl_ptr].dirty) ? TAG_W'(ent_q[repl_ptr].tag) : '0;
      wb_data    <= (replace && ent_q[repl_ptr].dirty) ? DATA_W'(ent_q[repl_ptr].data) : '0;
    end
  end

endmodule

// File: tb/tb_victim_buffer.sv
// Bench for victim_buffer: directed scenarios plus random traffic, every cycle compared
// against a slot-level reference model of the insert/probe rules.
module tb_victim_buffer;

  localparam int N  = 4;
  localparam int TW = 26;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          lookup_valid;
  logic [TW-1:0] lookup_tag;
  logic          insert_valid;
  logic [TW-1:0] insert_tag;
  logic [DW-1:0] insert_data;
  logic          insert_dirty;
  logic          resp_valid, resp_hit, resp_dirty, wb_valid;
  logic [DW-1:0] resp_data, wb_data;
  logic [TW-1:0] wb_tag;
  logic [2:0]    occupancy;

  int total = 0;
  int bad   = 0;

  victim_buffer #(.ENTRIES(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_tag(lookup_tag),
    .insert_valid(insert_valid), .insert_tag(insert_tag),
    .insert_data(insert_data), .insert_dirty(insert_dirty),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data), .resp_dirty(resp_dirty),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit            m_valid [N];
  bit            m_dirty [N];
  logic [TW-1:0] m_tag   [N];
  logic [DW-1:0] m_data  [N];
  int            m_ptr;

  logic          e_rv, e_hit, e_rdirty, e_wbv;
  logic [DW-1:0] e_rdata, e_wbd;
  logic [TW-1:0] e_wbt;
  int            e_occ;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; m_data[i] = '0;
    end
    m_ptr = 0;
  endtask

  task automatic model_step(input logic lv, input logic [TW-1:0] lt, input logic iv,
                            input logic [TW-1:0] it, input logic [DW-1:0] id, input logic idr);
    int  hit, slot;
    bit  merge;
    hit = -1; slot = -1; merge = 0;
    for (int i = 0; i < N; i++) if (lv && m_valid[i] && m_tag[i] == lt) hit = i;
    e_rv     = lv;
    e_hit    = (hit >= 0);
    e_rdata  = (hit >= 0) ? m_data[hit] : '0;
    e_rdirty = (hit >= 0) ? m_dirty[hit] : 1'b0;
    e_wbv = 0; e_wbt = '0; e_wbd = '0;
    if (iv) begin
      for (int i = 0; i < N; i++) if (m_valid[i] && m_tag[i] == it) slot = i;
      if (slot >= 0) merge = (slot != hit);
      else if (hit >= 0) slot = hit;
      else begin
        for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
        if (slot < 0) begin
          slot = m_ptr;
          if (m_dirty[slot]) begin
            e_wbv = 1; e_wbt = m_tag[slot]; e_wbd = m_data[slot];
          end
          m_ptr = (m_ptr + 1) % N;
        end
      end
    end
    if (hit >= 0) m_valid[hit] = 0;
    if (iv) begin
      m_dirty[slot] = merge ? (m_dirty[slot] | idr) : idr;
      m_valid[slot] = 1; m_tag[slot] = it; m_data[slot] = id;
    end
    e_occ = 0;
    for (int i = 0; i < N; i++) e_occ += int'(m_valid[i]);
  endtask

  task automatic cyc(input logic lv, input logic [TW-1:0] lt, input logic iv,
                     input logic [TW-1:0] it, input logic [DW-1:0] id, input logic idr);
    lookup_valid = lv; lookup_tag = lt;
    insert_valid = iv; insert_tag = it; insert_data = id; insert_dirty = idr;
    model_step(lv, lt, iv, it, id, idr);
    @(posedge clk); #1;
    check("resp_valid", 64'(resp_valid), 64'(e_rv));
    check("resp_hit",   64'(resp_hit),   64'(e_hit));
    check("resp_data",  64'(resp_data),  64'(e_rdata));
    check("resp_dirty", 64'(resp_dirty), 64'(e_rdirty));
    check("wb_valid",   64'(wb_valid),   64'(e_wbv));
    check("wb_tag",     64'(wb_tag),     64'(e_wbt));
    check("wb_data",    64'(wb_data),    64'(e_wbd));
    check("occupancy",  64'(occupancy),  64'(e_occ));
  endtask

  task automatic idle();
    cyc(0, '0, 0, '0, '0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_wb_valid",   64'(wb_valid),   64'd0);
    check("rst_occupancy",  64'(occupancy),  64'd0);
  endtask

  initial begin
    reset = 1'b1;
    lookup_valid = 0; lookup_tag = '0;
    insert_valid = 0; insert_tag = '0; insert_data = '0; insert_dirty = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Probe of an empty buffer misses
    cyc(1, 26'h10, 0, '0, '0, 0);
    check("empty_probe_hit", 64'(resp_hit), 64'd0);

    // Fill, then probe out 0x3
    for (int t = 1; t <= 4; t++) cyc(0, '0, 1, TW'(t), DW'(32'hA0 + t), t == 2);
    check("fill_occ", 64'(occupancy), 64'd4);
    cyc(1, 26'h3, 0, '0, '0, 0);
    check("probe3_data", 64'(resp_data), 64'hA3);
    check("probe3_occ",  64'(occupancy), 64'd3);

    // Refill slot 2, then two replacements: clean victim dropped, dirty victim written back
    cyc(0, '0, 1, 26'h3, 32'hA3, 0);
    cyc(0, '0, 1, 26'h5, 32'hA5, 0);
    check("repl1_no_wb", 64'(wb_valid), 64'd0);
    cyc(0, '0, 1, 26'h6, 32'hA6, 0);
    check("repl2_wb_tag",  64'(wb_tag),  64'h2);
    check("repl2_wb_data", 64'(wb_data), 64'hA2);

    // Swap: probe hit and insert on a full buffer
    cyc(1, 26'h4, 1, 26'h9, 32'hA9, 0);
    check("swap_data", 64'(resp_data), 64'hA4);
    check("swap_no_wb", 64'(wb_valid), 64'd0);
    cyc(1, 26'h9, 0, '0, '0, 0);

    // Overwrite of an existing tag merges dirty
    do_reset();
    cyc(0, '0, 1, 26'h7, 32'hB0, 0);
    cyc(0, '0, 1, 26'h7, 32'hB1, 1);
    check("merge_occ", 64'(occupancy), 64'd1);
    cyc(1, 26'h7, 0, '0, '0, 0);
    check("merge_dirty", 64'(resp_dirty), 64'd1);

    // Same-tag probe and insert: old data returned, new data kept with the new dirty bit
    cyc(0, '0, 1, 26'h8, 32'hC0, 1);
    cyc(1, 26'h8, 1, 26'h8, 32'hC1, 0);
    cyc(1, 26'h8, 0, '0, '0, 0);
    check("same_tag_dirty", 64'(resp_dirty), 64'd0);

    // Random traffic over a small tag space so hits, merges and replacements all occur
    for (int c = 0; c < 600; c++) begin
      logic lv, iv;
      lv = ($urandom_range(0, 2) != 0);
      iv = ($urandom_range(0, 2) != 0);
      cyc(lv, TW'($urandom_range(1, 8)), iv, TW'($urandom_range(1, 8)), DW'($urandom), 1'($urandom));
    end

    // Reset lands while a response and a write-back are being presented
    do_reset();
    for (int t = 1; t <= 4; t++) cyc(0, '0, 1, TW'(t), DW'(32'hD0 + t), 1);
    cyc(1, 26'h20, 1, 26'h5, 32'hD5, 0);
    check("pre_rst_wb", 64'(wb_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_wb_valid",   64'(wb_valid),   64'd0);
    check("mid_rst_wb_tag",     64'(wb_tag),     64'd0);
    check("mid_rst_occ",        64'(occupancy),  64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    cyc(1, 26'h2, 0, '0, '0, 0);
    check("post_rst_miss", 64'(resp_hit), 64'd0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/victim_buffer.md
Name: victim_buffer

Overview:
- Small fully-associative victim cache between the direct-mapped L1 and the next memory level.
- Captures lines evicted from L1 and answers L1-miss probes with a one-cycle registered response.
- On a hit, the line moves back to L1 and the entry is freed (swap semantics).
- When a dirty victim is displaced from the buffer, it is emitted on a write-back port.

Parameters:
- ENTRIES, 4, number of fully-associative entries; power of two, at least 2.
- TAG_W, 26, line address (tag plus index) width.
- DATA_W, 32, line data width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- lookup_valid  in  1  L1-miss probe request this cycle.
- lookup_tag  in  TAG_W  line address being probed.
- insert_valid  in  1  L1 eviction being written into the buffer this cycle.
- insert_tag  in  TAG_W  evicted line address.
- insert_data  in  DATA_W  evicted line data.
- insert_dirty  in  1  evicted line is modified.
- resp_valid  out  1  registered response to a probe from the previous cycle.
- resp_hit  out  1  probe hit.
- resp_data  out  DATA_W  hit line data; 0 on miss.
- resp_dirty  out  1  hit line dirty flag.
- wb_valid  out  1  one-cycle pulse: a dirty valid entry was displaced.
- wb_tag  out  TAG_W  displaced line address.
- wb_data  out  DATA_W  displaced line data.
- occupancy  out  $clog2(ENTRIES)+1  count of valid entries.

Behaviour:
- Reset (async, active-high):
  - All entry valid bits cleared; repl_ptr set to 0.
  - All outputs 0: resp_*, wb_*, occupancy.
  - If reset asserts mid-operation, any pending response or write-back is dropped.
- Probe, issued in cycle N:
  - lookup_tag is compared combinationally against all valid entries, using pre-edge state.
  - resp_valid is 1 in cycle N+1 only.
  - On a hit, the entry's valid bit clears at the end-of-N edge.
  - On a miss: resp_hit = 0, resp_data = 0, resp_dirty = 0.
  - Tags are unique, so at most one entry can match.
- Insert, issued in cycle N; slot choice in priority order:
  1. A valid entry whose tag equals insert_tag: overwrite data; dirty becomes old | new; no write-back.
  2. Else, the slot freed by a same-cycle probe hit (swap): no write-back.
  3. Else, the lowest-index invalid entry.
  4. Else (full), the entry at repl_ptr. repl_ptr then increments modulo ENTRIES (wraps ENTRIES-1 to 0). If that entry was dirty: wb_valid = 1 in N+1 with its tag and data. If clean, it is dropped silently.
- repl_ptr advances only on a full-buffer replacement.
- Probe and insert of the same tag in one cycle: the probe returns the old data and hit = 1; the slot then holds the new data and is valid, with dirty = insert_dirty.
- occupancy is registered and reflects post-edge state:
  - +1 for an insert into a free slot.
  - -1 for a probe hit with no insert.
  - Unchanged for a swap or a replacement.
  - Never exceeds ENTRIES and never underflows.
- Everything except the response path idles when neither request is valid.
- The response and wb outputs hold 0 on cycles without a pulse.

Decomposition:
- Shared package vc_pkg holds:
  - vc_entry_t struct {valid, dirty, tag, data}.
  - Default ENTRIES, TAG_W, DATA_W constants.
  - A function clog2-safe width for occupancy.
- One sub-module, vc_first_free: a parameterised priority encoder producing {found, index} from the valid vector. Reused by the L1 fill logic.
- Entry storage is flop-based (array of vc_entry_t); no RAM macro.

Test Plan:
- Reset, then probe tag 0x10 -> next cycle resp_valid = 1, resp_hit = 0, resp_data = 0; occupancy 0.
- Insert tags 0x1, 0x2, 0x3, 0x4 (data 0xA1..0xA4, tag 0x2 dirty), then probe 0x3 -> resp_hit = 1, resp_data = 0xA3; occupancy goes 4 -> 3.
- Fill 4 entries (0x2 dirty in slot 1), then insert 0x5 and 0x6 back-to-back -> first overwrites slot 0 (0x1, clean): no wb. Second overwrites slot 1: wb_valid = 1 with wb_tag = 0x2, wb_data = 0xA2. repl_ptr = 2; occupancy stays 4.
- Full buffer; same cycle, probe hit on 0x4 and insert 0x9 -> resp returns 0xA4; 0x9 lands in 0x4's slot; no wb; occupancy 4.
- Insert 0x7 clean with data 0xB0, then 0x7 dirty with data 0xB1 -> single entry; a probe returns 0xB1 with resp_dirty = 1; occupancy 1.
- Assert reset mid-cycle between an insert edge and a response cycle -> all outputs 0 immediately; a subsequent probe of any prior tag misses.
